// File: rtl/lstm_seq_driver.sv
// Sequencer around an LSTM cell: latches X, holds the recurrent c/h state and streams out h.
// Optional LSTM_STATE_INIT_EN adds init_c/init_h ports used on x_first instead of zero.
module lstm_seq_driver #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FRACT_WIDTH  = 8,
  parameter int unsigned CELL_LATENCY = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic                  x_first,
  input  logic                  x_last,
`ifdef LSTM_STATE_INIT_EN
  input  logic [DATA_WIDTH-1:0] init_c,
  input  logic [DATA_WIDTH-1:0] init_h,
`endif
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c_in,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  h_valid,
  input  logic                  h_ready,
  output logic [DATA_WIDTH-1:0] h_data,
  output logic                  h_last,
  output logic [CNT_WIDTH-1:0]  step_cnt,
  output logic                  busy
);

  if (CELL_LATENCY < 1 || CELL_LATENCY > 15 || FRACT_WIDTH > DATA_WIDTH) begin : g_param_err
    $error("lstm_seq_driver: illegal CELL_LATENCY or FRACT_WIDTH");
  end

  localparam logic [3:0] WaitInit = 4'(CELL_LATENCY);

  typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

  state_e                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] cell_x_q, cell_x_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
  logic                  h_valid_q, h_valid_d;
  logic                  h_last_q, h_last_d;
  logic [CNT_WIDTH-1:0]  step_q, step_d;
  logic [DATA_WIDTH-1:0] seed_c, seed_h;

`ifdef LSTM_STATE_INIT_EN
  assign seed_c = init_c;
  assign seed_h = init_h;
`else
  assign seed_c = '0;
  assign seed_h = '0;
`endif

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    last_d    = last_q;
    cell_x_d  = cell_x_q;
    c_d       = c_q;
    h_d       = h_q;
    h_data_d  = h_data_q;
    h_valid_d = h_valid_q;
    h_last_d  = h_last_q;
    step_d    = step_q;
    unique case (state_q)
      StIdle: begin
        if (x_valid) begin
          cell_x_d = x_data;
          last_d   = x_last;
          if (x_first) begin
            c_d    = seed_c;
            h_d    = seed_h;
            step_d = '0;
          end
          wait_d  = WaitInit;
          state_d = StCalc;
        end
      end
      StCalc: begin
        wait_d = wait_q - 4'd1;
        // Cell outputs are valid on the edge where the countdown expires.
        if (wait_q == 4'd1) begin
          c_d       = cell_c_out;
          h_d       = cell_h_out;
          h_data_d  = cell_h_out;
          h_last_d  = last_q;
          h_valid_d = 1'b1;
          step_d    = (step_q == '1) ? step_q : step_q + 1'b1;
          state_d   = StOut;
        end
      end
      StOut: begin
        if (h_ready) begin
          h_valid_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      last_q    <= 1'b0;
      cell_x_q  <= '0;
      c_q       <= '0;
      h_q       <= '0;
      h_data_q  <= '0;
      h_valid_q <= 1'b0;
      h_last_q  <= 1'b0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      last_q    <= last_d;
      cell_x_q  <= cell_x_d;
      c_q       <= c_d;
      h_q       <= h_d;
      h_data_q  <= h_data_d;
      h_valid_q <= h_valid_d;
      h_last_q  <= h_last_d;
      step_q    <= step_d;
    end
  end

  assign x_ready   = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign cell_x    = cell_x_q;
  assign cell_c_in = c_q;
  assign cell_h_in = h_q;
  assign h_valid   = h_valid_q;
  assign h_data    = h_data_q;
  assign h_last    = h_last_q;
  assign step_cnt  = step_q;

endmodule

// File: tb/tb_lstm_seq_driver.sv
// Bench for lstm_seq_driver: two instances (cell latency 1 and 4) with a toy adder cell model,
// compared against an arithmetic model of the recurrent c/h/step state.
module tb_lstm_seq_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid   [2];
  logic        x_ready   [2];
  logic [15:0] x_data    [2];
  logic        x_first   [2];
  logic        x_last    [2];
  logic [15:0] cell_x    [2];
  logic [15:0] cell_c_in [2];
  logic [15:0] cell_h_in [2];
  logic [15:0] cell_c_out[2];
  logic [15:0] cell_h_out[2];
  logic        h_valid   [2];
  logic        h_ready   [2];
  logic [15:0] h_data    [2];
  logic        h_last    [2];
  logic [15:0] step_cnt  [2];
  logic        busy      [2];
`ifdef LSTM_STATE_INIT_EN
  logic [15:0] init_c    [2];
  logic [15:0] init_h    [2];
`endif

  logic [15:0] mc[2];
  logic [15:0] mh[2];
  logic [15:0] mcnt[2];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign cell_c_out[0] = cell_c_in[0] + cell_x[0];
  assign cell_h_out[0] = cell_h_in[0] + 16'h0100;
  assign cell_c_out[1] = cell_c_in[1] + cell_x[1];
  assign cell_h_out[1] = cell_h_in[1] + 16'h0100;

  lstm_seq_driver #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .CELL_LATENCY(1), .CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .x_valid(x_valid[0]), .x_ready(x_ready[0]), .x_data(x_data[0]),
    .x_first(x_first[0]), .x_last(x_last[0]),
`ifdef LSTM_STATE_INIT_EN
    .init_c(init_c[0]), .init_h(init_h[0]),
`endif
    .cell_x(cell_x[0]), .cell_c_in(cell_c_in[0]), .cell_h_in(cell_h_in[0]),
    .cell_c_out(cell_c_out[0]), .cell_h_out(cell_h_out[0]),
    .h_valid(h_valid[0]), .h_ready(h_ready[0]), .h_data(h_data[0]), .h_last(h_last[0]),
    .step_cnt(step_cnt[0]), .busy(busy[0])
  );

  lstm_seq_driver #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .CELL_LATENCY(4), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst),
    .x_valid(x_valid[1]), .x_ready(x_ready[1]), .x_data(x_data[1]),
    .x_first(x_first[1]), .x_last(x_last[1]),
`ifdef LSTM_STATE_INIT_EN
    .init_c(init_c[1]), .init_h(init_h[1]),
`endif
    .cell_x(cell_x[1]), .cell_c_in(cell_c_in[1]), .cell_h_in(cell_h_in[1]),
    .cell_c_out(cell_c_out[1]), .cell_h_out(cell_h_out[1]),
    .h_valid(h_valid[1]), .h_ready(h_ready[1]), .h_data(h_data[1]), .h_last(h_last[1]),
    .step_cnt(step_cnt[1]), .busy(busy[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mc[d]   = 16'h0;
      mh[d]   = 16'h0;
      mcnt[d] = 16'h0;
    end
  endtask

  // One full step: offer sample, watch the calc window, hold off bp cycles, then hand off.
  task automatic run_step(input int d, input logic [15:0] data, input bit first, input bit last,
                          input int bp);
    logic [15:0] c_prev, h_prev;
    int n;
    int lat;
    lat = (d == 0) ? 1 : 4;
    if (first) begin
`ifdef LSTM_STATE_INIT_EN
      mc[d] = init_c[d];
      mh[d] = init_h[d];
`else
      mc[d] = 16'h0;
      mh[d] = 16'h0;
`endif
      mcnt[d] = 16'h0;
    end
    c_prev = mc[d];
    h_prev = mh[d];
    mc[d]  = mc[d] + data;
    mh[d]  = mh[d] + 16'h0100;
    if (mcnt[d] != 16'hffff) mcnt[d] = mcnt[d] + 16'h1;

    check_eq("idle_x_ready", 32'(x_ready[d]), 32'd1);
    x_valid[d] = 1'b1;
    x_data[d]  = data;
    x_first[d] = first;
    x_last[d]  = last;
    @(posedge clk); #1;
    x_valid[d] = 1'b0;
    x_first[d] = 1'b0;
    x_last[d]  = 1'b0;
    x_data[d]  = 16'hdead;

    n = 0;
    while (h_valid[d] !== 1'b1 && n < 40) begin
      check_eq("calc_x_ready", 32'(x_ready[d]), 32'd0);
      check_eq("calc_busy", 32'(busy[d]), 32'd1);
      check_eq("calc_cell_x", 32'(cell_x[d]), 32'(data));
      check_eq("calc_c_in", 32'(cell_c_in[d]), 32'(c_prev));
      check_eq("calc_h_in", 32'(cell_h_in[d]), 32'(h_prev));
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 32'(n), 32'(lat));
    check_eq("h_data", 32'(h_data[d]), 32'(mh[d]));
    check_eq("h_last", 32'(h_last[d]), 32'(last));
    check_eq("step_cnt", 32'(step_cnt[d]), 32'(mcnt[d]));

    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check_eq("bp_h_valid", 32'(h_valid[d]), 32'd1);
      check_eq("bp_h_data", 32'(h_data[d]), 32'(mh[d]));
      check_eq("bp_h_last", 32'(h_last[d]), 32'(last));
      check_eq("bp_x_ready", 32'(x_ready[d]), 32'd0);
    end

    h_ready[d] = 1'b1;
    @(posedge clk); #1;
    h_ready[d] = 1'b0;
    check_eq("post_h_valid", 32'(h_valid[d]), 32'd0);
    check_eq("post_busy", 32'(busy[d]), 32'd0);
    check_eq("post_c_reg", 32'(cell_c_in[d]), 32'(mc[d]));
    check_eq("post_h_reg", 32'(cell_h_in[d]), 32'(mh[d]));
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      x_valid[d] = 1'b0;
      x_data[d]  = 16'h0;
      x_first[d] = 1'b0;
      x_last[d]  = 1'b0;
      h_ready[d] = 1'b0;
`ifdef LSTM_STATE_INIT_EN
      init_c[d]  = 16'h0;
      init_h[d]  = 16'h0;
`endif
    end
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_busy", 32'(busy[d]), 32'd0);
      check_eq("rst_h_valid", 32'(h_valid[d]), 32'd0);
      check_eq("rst_h_last", 32'(h_last[d]), 32'd0);
      check_eq("rst_h_data", 32'(h_data[d]), 32'd0);
      check_eq("rst_step_cnt", 32'(step_cnt[d]), 32'd0);
      check_eq("rst_cell_x", 32'(cell_x[d]), 32'd0);
      check_eq("rst_c_in", 32'(cell_c_in[d]), 32'd0);
      check_eq("rst_h_in", 32'(cell_h_in[d]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_eq("rel_x_ready0", 32'(x_ready[0]), 32'd1);
    check_eq("rel_x_ready1", 32'(x_ready[1]), 32'd1);

    // Three-step sequence, latency 1.
    run_step(0, 16'h0100, 1'b1, 1'b0, 0);
    run_step(0, 16'h0200, 1'b0, 1'b0, 0);
    run_step(0, 16'h0300, 1'b0, 1'b1, 0);
    check_eq("seq_c_reg", 32'(cell_c_in[0]), 32'h0600);
    check_eq("seq_step_cnt", 32'(step_cnt[0]), 32'd3);
    check_eq("seq_last_h", 32'(h_data[0]), 32'h0300);

    // Restart clears state; step_cnt survives x_last until then.
    run_step(0, 16'h0500, 1'b1, 1'b0, 0);
    check_eq("restart_h_data", 32'(h_data[0]), 32'h0100);
    check_eq("restart_step_cnt", 32'(step_cnt[0]), 32'd1);

    // Backpressure on both latencies.
    run_step(0, 16'h0011, 1'b0, 1'b1, 10);
    run_step(1, 16'h0100, 1'b1, 1'b0, 0);
    run_step(1, 16'h0200, 1'b0, 1'b0, 10);
    run_step(1, 16'h0300, 1'b0, 1'b1, 0);
    check_eq("lat4_c_reg", 32'(cell_c_in[1]), 32'h0600);
    check_eq("lat4_step_cnt", 32'(step_cnt[1]), 32'd3);

`ifdef LSTM_STATE_INIT_EN
    init_c[0] = 16'h0080;
    init_h[0] = 16'h0040;
    run_step(0, 16'h0100, 1'b1, 1'b1, 0);
    check_eq("init_h_data", 32'(h_data[0]), 32'h0140);
    check_eq("init_c_reg", 32'(cell_c_in[0]), 32'h0180);
`endif

    for (int i = 0; i < 40; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
`ifdef LSTM_STATE_INIT_EN
      init_c[d] = 16'($urandom);
      init_h[d] = 16'($urandom);
`endif
      run_step(d, 16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a latency-4 calculation.
    x_valid[1] = 1'b1;
    x_data[1]  = 16'h0abc;
    x_first[1] = 1'b1;
    @(posedge clk); #1;
    x_valid[1] = 1'b0;
    x_first[1] = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_busy", 32'(busy[1]), 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("mid_rst_busy", 32'(busy[d]), 32'd0);
      check_eq("mid_rst_h_valid", 32'(h_valid[d]), 32'd0);
      check_eq("mid_rst_step_cnt", 32'(step_cnt[d]), 32'd0);
      check_eq("mid_rst_c_in", 32'(cell_c_in[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    check_eq("after_rst_x_ready0", 32'(x_ready[0]), 32'd1);
    check_eq("after_rst_x_ready1", 32'(x_ready[1]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("after_rst_no_h", 32'(h_valid[1]), 32'd0);
    end

    // First sample after reset without x_first behaves as a fresh sequence.
`ifdef LSTM_STATE_INIT_EN
    init_c[0] = 16'h0;
    init_h[0] = 16'h0;
`endif
    run_step(0, 16'h0700, 1'b0, 1'b1, 0);
    check_eq("nofirst_h_data", 32'(h_data[0]), 32'h0100);
    check_eq("nofirst_step_cnt", 32'(step_cnt[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lstm_seq_driver.md
Name: lstm_seq_driver

Overview:
- Sequencer on the other side of the LSTM cell interface: it drives the cell's X, c_in and h_in and captures its c_out and h_out.
- Accepts a valid/ready stream of Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH input samples.
- Holds the recurrent c/h state between time steps and emits the h sequence on a valid/ready output stream.
- Sits between the input feature buffer and the downstream dense/classifier stage.

Parameters:
DATA_WIDTH, 16, width of every data word (X, c, h)
FRACT_WIDTH, 8, fractional bits; pass-through only, no arithmetic in this block
CELL_LATENCY, 1, cycles from stable cell inputs to valid cell outputs; legal range 1..15
CNT_WIDTH, 16, width of step counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
x_valid  in  1  input sample valid
x_ready  out  1  driver can accept sample
x_data  in  DATA_WIDTH  input sample X
x_first  in  1  sample is the first of a sequence; clear state
x_last  in  1  sample is the last of a sequence
cell_x  out  DATA_WIDTH  X to cell, registered
cell_c_in  out  DATA_WIDTH  previous cell state to cell
cell_h_in  out  DATA_WIDTH  previous hidden state to cell
cell_c_out  in  DATA_WIDTH  new cell state from cell
cell_h_out  in  DATA_WIDTH  new hidden state from cell
h_valid  out  1  output hidden state valid
h_ready  in  1  downstream accepts
h_data  out  DATA_WIDTH  hidden state for this step
h_last  out  1  h_data belongs to the last step of a sequence
step_cnt  out  CNT_WIDTH  completed steps in current sequence
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - c_reg, h_reg, cell_x, h_data, step_cnt all 0.
  - h_valid=0, h_last=0, busy=0.
  - x_ready=1 once rst is released (combinational from state only).
- cell_c_in=c_reg and cell_h_in=h_reg continuously; all outputs come from registers or decoded state, with no combinational x_valid->x_ready or h_ready->h_valid path.
- FSM IDLE -> CALC -> OUT -> IDLE.
- IDLE: x_ready=1. On x_valid&x_ready:
  - cell_x<=x_data; last_q<=x_last.
  - If x_first: c_reg<=0, h_reg<=0, step_cnt<=0.
  - wait_cnt<=CELL_LATENCY; go to CALC.
- CALC: x_ready=0; wait_cnt decrements each cycle. On the edge where wait_cnt==1:
  - c_reg<=cell_c_out; h_reg<=cell_h_out.
  - h_data<=cell_h_out; h_last<=last_q; h_valid<=1.
  - step_cnt<=step_cnt+1, saturating at all-ones.
  - Go to OUT.
- Latency: acceptance edge E0 -> h_valid high after edge E0+CELL_LATENCY. Step-to-step throughput is CELL_LATENCY+2 cycles when h_ready is held high.
- OUT: h_valid held and h_data/h_last stable until h_valid&h_ready. On that edge h_valid<=0 and state goes to IDLE. No new sample is accepted in the same cycle.
- x_first=0 on the very first sample after reset: state is already 0, so behaviour is identical to x_first=1.
- x_first=1 and x_last=1 together: single-step sequence; h_last=1 on its output.
- step_cnt is not cleared by x_last; it is cleared only by the next x_first or by reset.
- Reset asserted mid-CALC or mid-OUT: the pending step is discarded, all registers return to reset values, and no h handshake occurs.
- x_valid while busy: ignored (x_ready=0); the upstream must hold the sample.

Optional Feature:
- Macro LSTM_STATE_INIT_EN.
- Defined: adds input ports init_c and init_h (DATA_WIDTH each). On an x_first acceptance, c_reg<=init_c and h_reg<=init_h instead of 0. Reset values are still 0.
- Undefined: those ports do not exist and x_first clears the state to 0.

Test Plan:
- Bench cell model: cell_c_out = cell_c_in + cell_x, cell_h_out = cell_h_in + 16'h0100, CELL_LATENCY=1.
  - Three samples 16'h0100, 16'h0200, 16'h0300; first sample has x_first=1, third has x_last=1.
  - Expect h_data = 0100, 0200, 0300 with h_last only on the third.
  - Expect c_reg=0600 and step_cnt=3.
- Same setup with CELL_LATENCY=4: h_valid rises exactly 4 edges after the acceptance edge. The bench checks the cell input registers are stable during CALC.
- Backpressure: hold h_ready=0 for 10 cycles in OUT.
  - h_valid, h_data and h_last stay constant.
  - x_ready=0 throughout.
  - Sample accepted exactly one cycle after the handshake.
- Sequence restart: after the 3-step sequence, send x_first=1 with x_data=16'h0500. Expect cell_c_in=0 and cell_h_in=0 during CALC, h_data=0100, step_cnt=1.
- Reset in CALC: deassert rst for one cycle. Expect h_valid never asserted, busy=0, step_cnt=0, x_ready=1 after release.
- With LSTM_STATE_INIT_EN: init_c=16'h0080, init_h=16'h0040, x_first sample 16'h0100. Expect h_data=0140 and c_reg=0180.
